// File: rtl/hpi_responder_pkg.sv
// Shared definitions for the HPI responder slice.
// Contents: the HPI register enum, the STATUS bit indices, the read latency
// and a helper that packs the STATUS word.
package hpi_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_MAILBOX = 2'd1,
    REG_ADDRESS = 2'd2,
    REG_STATUS  = 2'd3
  } hpi_reg_e;

  localparam int ST_DEV_MBX  = 0;
  localparam int ST_HOST_MBX = 1;
  localparam int ST_OVF      = 2;

  // Clock edges from strobe detection to read data on the bus
  localparam int HPI_RD_LAT  = 2;

  localparam int HPI_DATA_W  = 16;

  function automatic logic [HPI_DATA_W-1:0] status_word(input logic dev_full,
                                                        input logic host_full,
                                                        input logic ovf);
    logic [HPI_DATA_W-1:0] s;
    s              = '0;
    s[ST_DEV_MBX]  = dev_full;
    s[ST_HOST_MBX] = host_full;
    s[ST_OVF]      = ovf;
    return s;
  endfunction

endpackage

// File: rtl/hpi_responder_if.sv
// HPI host-port control signals (everything except the bidirectional data bus,
// which stays a plain inout port so tristate resolution happens at a module pin).
//   OTG_ADDR   : register select (DATA, MAILBOX, ADDRESS, STATUS)
//   OTG_CS_N   : chip select, active low
//   OTG_RD_N   : read strobe, active low
//   OTG_WR_N   : write strobe, active low
//   OTG_RST_N  : chip reset, active low
//   OTG_INT    : device->host mailbox full interrupt
interface hpi_responder_if;
  logic [1:0] OTG_ADDR;
  logic       OTG_CS_N;
  logic       OTG_RD_N;
  logic       OTG_WR_N;
  logic       OTG_RST_N;
  logic       OTG_INT;

  modport master (
    output OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N,
    input  OTG_INT
  );

  modport slave (
    input  OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N,
    output OTG_INT
  );
endinterface

// File: rtl/hpi_responder_dpram.sv
// True dual-port synchronous word RAM behind the HPI responder.
//   Port A (HPI side)  : a_addr, a_we, a_wdata, a_rdata (1-cycle read)
//   Port B (local side): b_addr, b_we, b_wdata, b_rdata (1-cycle read)
//   Clk, Reset         : Reset clears only the read registers, never the array
// When both ports write the same word in one cycle, port A's data is kept.
module hpi_dpram #(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [15:0]   a_wdata,
  output logic [15:0]   a_rdata,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [15:0]   b_wdata,
  output logic [15:0]   b_rdata
);

  logic [15:0] mem [MEM_WORDS];
  logic        b_blocked;

  assign b_blocked = a_we && (a_addr == b_addr);

  always_ff @(posedge Clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we && !b_blocked) mem[b_addr] <= b_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/hpi_responder.sv
// HPI slave emulating the CY7C67200 host port for simulation/loopback builds.
//   Clk, Reset     : system clock, synchronous active-high reset
//   hpi (slave)    : OTG_ADDR/CS_N/RD_N/WR_N/RST_N in, OTG_INT out
//   OTG_DATA       : 16-bit bidirectional data, driven only during a read
//   loc_addr/loc_wdata/loc_we/loc_rdata : local memory port (1-cycle read)
//   loc_mbx_wdata/loc_mbx_we            : post the device->host mailbox
//   host_mbx/host_mbx_full/loc_mbx_ack  : host->device mailbox and its consume
// Memory index uses addr_q[AW:1], so MEM_WORDS must not exceed 32768.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int MEM_WORDS = 4096
) (
  input  logic                         Clk,
  input  logic                         Reset,
  hpi_responder_if.slave               hpi,
  inout  wire  [15:0]                  OTG_DATA,
  input  logic [$clog2(MEM_WORDS)-1:0] loc_addr,
  input  logic [15:0]                  loc_wdata,
  input  logic                         loc_we,
  output logic [15:0]                  loc_rdata,
  input  logic [15:0]                  loc_mbx_wdata,
  input  logic                         loc_mbx_we,
  output logic [15:0]                  host_mbx,
  output logic                         host_mbx_full,
  input  logic                         loc_mbx_ack
);

  localparam int AW = $clog2(MEM_WORDS);

  logic rst_int;
  assign rst_int = Reset | ~hpi.OTG_RST_N;

  // Stage p0: raw bus registered once
  logic        cs_n_p0, rd_n_p0, wr_n_p0;
  logic [1:0]  addr_p0;
  logic [15:0] data_p0;
  logic        act_q;

  // Staging keeps sampling through reset so a held strobe is seen as
  // already active on release; act_q forced high blocks its re-detection.
  always_ff @(posedge Clk) begin
    cs_n_p0 <= hpi.OTG_CS_N;
    rd_n_p0 <= hpi.OTG_RD_N;
    wr_n_p0 <= hpi.OTG_WR_N;
    addr_p0 <= hpi.OTG_ADDR;
    data_p0 <= OTG_DATA;
  end

  logic     act_p0, stb_p0, wr_stb, rd_stb;
  hpi_reg_e sel_p0;

  // Both strobes low is treated as idle
  assign act_p0 = ~cs_n_p0 & (rd_n_p0 ^ wr_n_p0);
  assign stb_p0 = act_p0 & ~act_q & ~rst_int;
  assign wr_stb = stb_p0 & ~wr_n_p0;
  assign rd_stb = stb_p0 & ~rd_n_p0;
  assign sel_p0 = hpi_reg_e'(addr_p0);

  always_ff @(posedge Clk) begin
    if (rst_int) act_q <= 1'b1;
    else         act_q <= act_p0;
  end

  // Architectural state
  logic [15:0] addr_q, rdata_q, dev_mbx_q, host_mbx_q;
  logic        dev_full_q, host_full_q, ovf_q;

  // Memory
  logic [15:0] mem_rdata_p1;
  logic        mem_we;

  assign mem_we = wr_stb && (sel_p0 == REG_DATA);

  hpi_dpram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_dpram (
    .Clk     (Clk),
    .Reset   (rst_int),
    .a_addr  (addr_q[AW:1]),
    .a_we    (mem_we),
    .a_wdata (data_p0),
    .a_rdata (mem_rdata_p1),
    .b_addr  (loc_addr),
    .b_we    (loc_we),
    .b_wdata (loc_wdata),
    .b_rdata (loc_rdata)
  );

  // Stage p1: action committed, read value captured
  logic        vld_p1, inc_p1, mem_sel_p1;
  logic [15:0] reg_rdata_p1;

  always_ff @(posedge Clk) begin
    mem_sel_p1 <= (sel_p0 == REG_DATA);
    unique case (sel_p0)
      REG_MAILBOX: reg_rdata_p1 <= dev_mbx_q;
      REG_ADDRESS: reg_rdata_p1 <= addr_q;
      REG_STATUS:  reg_rdata_p1 <= status_word(dev_full_q, host_full_q, ovf_q);
      default:     reg_rdata_p1 <= '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rst_int) begin
      vld_p1      <= 1'b0;
      inc_p1      <= 1'b0;
      addr_q      <= '0;
      rdata_q     <= '0;
      dev_mbx_q   <= '0;
      dev_full_q  <= 1'b0;
      host_mbx_q  <= '0;
      host_full_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vld_p1 <= rd_stb;
      inc_p1 <= stb_p0 && (sel_p0 == REG_DATA);

      // Stage p2: read data lands, DATA access increments the address
      if (vld_p1) rdata_q <= mem_sel_p1 ? mem_rdata_p1 : reg_rdata_p1;
      if (inc_p1) addr_q <= addr_q + 16'd2;
      if (wr_stb && (sel_p0 == REG_ADDRESS)) addr_q <= {data_p0[15:1], 1'b0};

      // A new local post beats a simultaneous host read of the mailbox
      if (loc_mbx_we) begin
        dev_mbx_q  <= loc_mbx_wdata;
        dev_full_q <= 1'b1;
      end else if (rd_stb && (sel_p0 == REG_MAILBOX)) begin
        dev_full_q <= 1'b0;
      end

      // A host write racing an ack leaves full set and ovf untouched
      if (wr_stb && (sel_p0 == REG_MAILBOX)) begin
        host_mbx_q  <= data_p0;
        host_full_q <= 1'b1;
        if (host_full_q && !loc_mbx_ack) ovf_q <= 1'b1;
      end else if (loc_mbx_ack) begin
        host_full_q <= 1'b0;
      end

      if (rd_stb && (sel_p0 == REG_STATUS)) ovf_q <= 1'b0;
    end
  end

  assign hpi.OTG_INT   = dev_full_q;
  assign host_mbx      = host_mbx_q;
  assign host_mbx_full = host_full_q;

  // Bus is driven from the raw strobes so data appears as soon as rdata_q does
  logic drv_bus;
  assign drv_bus  = ~hpi.OTG_CS_N & ~hpi.OTG_RD_N & hpi.OTG_WR_N & ~rst_int;
  assign OTG_DATA = drv_bus ? rdata_q : {16{1'bz}};

endmodule

// File: tb/tb_hpi_responder.sv
module tb_hpi_responder;
  localparam int MEM_WORDS = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  wire  [15:0] otg_data;
  logic        drv_en;
  logic [15:0] drv_data;

  pullup pu_otg (otg_data);
  assign otg_data = drv_en ? drv_data : {16{1'bz}};

  hpi_responder_if hpi_if ();

  logic [11:0] loc_addr;
  logic [15:0] loc_wdata, loc_rdata, loc_mbx_wdata, host_mbx;
  logic        loc_we, loc_mbx_we, host_mbx_full, loc_mbx_ack;

  hpi_responder #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clk           (clk),
    .Reset         (reset),
    .hpi           (hpi_if),
    .OTG_DATA      (otg_data),
    .loc_addr      (loc_addr),
    .loc_wdata     (loc_wdata),
    .loc_we        (loc_we),
    .loc_rdata     (loc_rdata),
    .loc_mbx_wdata (loc_mbx_wdata),
    .loc_mbx_we    (loc_mbx_we),
    .host_mbx      (host_mbx),
    .host_mbx_full (host_mbx_full),
    .loc_mbx_ack   (loc_mbx_ack)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: register-map behaviour with plain arithmetic
  logic [15:0] mem_m [MEM_WORDS];
  logic [15:0] addr_m, dev_mbx_m, host_mbx_m;
  logic        dev_full_m, host_full_m, ovf_m;

  function automatic void m_reset();
    addr_m = 0; dev_mbx_m = 0; host_mbx_m = 0;
    dev_full_m = 0; host_full_m = 0; ovf_m = 0;
  endfunction

  function automatic int m_idx();
    return (int'(addr_m) / 2) % MEM_WORDS;
  endfunction

  function automatic void m_write(input logic [1:0] a, input logic [15:0] d);
    case (a)
      2'd0: begin mem_m[m_idx()] = d; addr_m = 16'((int'(addr_m) + 2) % 65536); end
      2'd1: begin if (host_full_m) ovf_m = 1; host_mbx_m = d; host_full_m = 1; end
      2'd2: addr_m = 16'((int'(d) / 2) * 2);
      default: ;
    endcase
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] a);
    logic [15:0] r;
    r = 0;
    case (a)
      2'd0: begin r = mem_m[m_idx()]; addr_m = 16'((int'(addr_m) + 2) % 65536); end
      2'd1: begin r = dev_mbx_m; dev_full_m = 0; end
      2'd2: r = addr_m;
      default: begin
        r = 16'(int'(dev_full_m) + 2 * int'(host_full_m) + 4 * int'(ovf_m));
        ovf_m = 0;
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_flags(input string nm);
    chk({nm, "_int"}, {15'd0, hpi_if.OTG_INT}, {15'd0, dev_full_m});
    chk({nm, "_hfull"}, {15'd0, host_mbx_full}, {15'd0, host_full_m});
    chk({nm, "_hmbx"}, host_mbx, host_mbx_m);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    hpi_if.OTG_ADDR = a; drv_data = d; drv_en = 1;
    hpi_if.OTG_CS_N = 0; hpi_if.OTG_WR_N = 0;
    @(negedge clk);
    hpi_if.OTG_CS_N = 1; hpi_if.OTG_WR_N = 1; drv_en = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    hpi_if.OTG_ADDR = a; hpi_if.OTG_CS_N = 0; hpi_if.OTG_RD_N = 0;
    repeat (3) @(posedge clk);
    #1 d = otg_data;
    @(negedge clk);
    hpi_if.OTG_CS_N = 1; hpi_if.OTG_RD_N = 1;
    @(negedge clk);
  endtask

  task automatic loc_read(input logic [11:0] a, output logic [15:0] d);
    @(negedge clk);
    loc_addr = a;
    @(posedge clk);
    #1 d = loc_rdata;
  endtask

  task automatic loc_wr(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    loc_addr = a; loc_wdata = d; loc_we = 1;
    @(negedge clk);
    loc_we = 0;
    mem_m[int'(a)] = d;
  endtask

  task automatic loc_post(input logic [15:0] d);
    @(negedge clk);
    loc_mbx_wdata = d; loc_mbx_we = 1;
    @(negedge clk);
    loc_mbx_we = 0;
    dev_mbx_m = d; dev_full_m = 1;
  endtask

  task automatic loc_ack();
    @(negedge clk);
    loc_mbx_ack = 1;
    @(negedge clk);
    loc_mbx_ack = 0;
    host_full_m = 0;
  endtask

  typedef struct packed {
    logic        is_wr;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv, ev, old0, old100;
    logic [1:0]  ra;
    int          op;

    reset = 1; drv_en = 0; drv_data = 0;
    hpi_if.OTG_ADDR = 0; hpi_if.OTG_CS_N = 1; hpi_if.OTG_RD_N = 1;
    hpi_if.OTG_WR_N = 1; hpi_if.OTG_RST_N = 1;
    loc_addr = 0; loc_wdata = 0; loc_we = 0;
    loc_mbx_wdata = 0; loc_mbx_we = 0; loc_mbx_ack = 0;
    m_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_loc_rdata", loc_rdata, 16'h0000);
    chk("rst_int", {15'd0, hpi_if.OTG_INT}, 16'h0000);
    chk("rst_hfull", {15'd0, host_mbx_full}, 16'h0000);
    chk("rst_hmbx", host_mbx, 16'h0000);
    chk("rst_bus_idle_z", otg_data, 16'hFFFF);
    hpi_if.OTG_CS_N = 0; hpi_if.OTG_RD_N = 0;
    @(negedge clk);
    chk("rst_bus_rd_z", otg_data, 16'hFFFF);
    hpi_if.OTG_CS_N = 1; hpi_if.OTG_RD_N = 1;
    @(negedge clk);
    reset = 0;

    // Fill the whole memory from the local port
    for (int i = 0; i < MEM_WORDS; i++) begin
      loc_addr = 12'(i); loc_wdata = 16'($urandom); loc_we = 1;
      mem_m[i] = loc_wdata;
      @(negedge clk);
    end
    loc_we = 0;

    // Table-driven register-map vectors
    vecs[0]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 2'd2, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 2'd2, 16'h1000, 16'h0000};
    vecs[3]  = '{1'b1, 2'd0, 16'hA1A1, 16'h0000};
    vecs[4]  = '{1'b1, 2'd0, 16'hB2B2, 16'h0000};
    vecs[5]  = '{1'b1, 2'd0, 16'hC3C3, 16'h0000};
    vecs[6]  = '{1'b1, 2'd2, 16'h1000, 16'h0000};
    vecs[7]  = '{1'b0, 2'd0, 16'h0000, 16'hA1A1};
    vecs[8]  = '{1'b0, 2'd0, 16'h0000, 16'hB2B2};
    vecs[9]  = '{1'b0, 2'd0, 16'h0000, 16'hC3C3};
    vecs[10] = '{1'b0, 2'd2, 16'h0000, 16'h1006};
    vecs[11] = '{1'b1, 2'd2, 16'hFFFE, 16'h0000};
    vecs[12] = '{1'b1, 2'd0, 16'h1234, 16'h0000};
    vecs[13] = '{1'b0, 2'd2, 16'h0000, 16'h0000};
    vecs[14] = '{1'b1, 2'd3, 16'hFFFF, 16'h0000};
    vecs[15] = '{1'b0, 2'd3, 16'h0000, 16'h0000};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].a, vecs[i].d);
        m_write(vecs[i].a, vecs[i].d);
      end else begin
        bus_read(vecs[i].a, rv);
        void'(m_read(vecs[i].a));
        chk($sformatf("vec%0d", i), rv, vecs[i].exp);
      end
    end

    // Wrapped address lands on the aliased word
    loc_read(12'hFFF, rv);
    chk("loc_wrap", rv, 16'h1234);

    // HPI write and local write to the same word in the same cycle
    bus_write(2'd2, 16'h0300); m_write(2'd2, 16'h0300);
    @(negedge clk);
    hpi_if.OTG_ADDR = 2'd0; drv_data = 16'h7777; drv_en = 1;
    hpi_if.OTG_CS_N = 0; hpi_if.OTG_WR_N = 0;
    @(negedge clk);
    hpi_if.OTG_CS_N = 1; hpi_if.OTG_WR_N = 1; drv_en = 0;
    loc_addr = 12'h180; loc_wdata = 16'h5555; loc_we = 1;
    @(negedge clk);
    loc_we = 0;
    @(negedge clk);
    m_write(2'd0, 16'h7777);
    loc_read(12'h180, rv);
    chk("collide_hpi_wins", rv, 16'h7777);
    bus_read(2'd2, rv); void'(m_read(2'd2));
    chk("collide_addr", rv, 16'h0302);

    // Device->host mailbox and interrupt
    loc_post(16'h00AB);
    chk("mbx_int_set", {15'd0, hpi_if.OTG_INT}, 16'h0001);
    bus_read(2'd3, rv); void'(m_read(2'd3));
    chk("mbx_status1", rv, 16'h0001);
    bus_read(2'd1, rv); void'(m_read(2'd1));
    chk("mbx_read", rv, 16'h00AB);
    chk("mbx_int_clr", {15'd0, hpi_if.OTG_INT}, 16'h0000);
    bus_read(2'd3, rv); void'(m_read(2'd3));
    chk("mbx_status0", rv, 16'h0000);

    // Host->device mailbox overflow
    bus_write(2'd1, 16'h0011); m_write(2'd1, 16'h0011);
    bus_write(2'd1, 16'h0022); m_write(2'd1, 16'h0022);
    chk("hmbx_val", host_mbx, 16'h0022);
    chk("hmbx_full", {15'd0, host_mbx_full}, 16'h0001);
    bus_read(2'd3, rv); void'(m_read(2'd3));
    chk("hmbx_status6", rv, 16'h0006);
    bus_read(2'd3, rv); void'(m_read(2'd3));
    chk("hmbx_status2", rv, 16'h0002);
    loc_ack();
    chk("hmbx_acked", {15'd0, host_mbx_full}, 16'h0000);
    bus_read(2'd3, rv); void'(m_read(2'd3));
    chk("hmbx_status0", rv, 16'h0000);

    // Long read strobe: one action only
    bus_write(2'd2, 16'h0100); m_write(2'd2, 16'h0100);
    ev = mem_m[16'h0080];
    @(negedge clk);
    hpi_if.OTG_ADDR = 2'd0; hpi_if.OTG_CS_N = 0; hpi_if.OTG_RD_N = 0;
    repeat (10) @(posedge clk);
    #1 chk("long_rd_data", otg_data, ev);
    @(negedge clk);
    hpi_if.OTG_CS_N = 1; hpi_if.OTG_RD_N = 1;
    @(negedge clk);
    void'(m_read(2'd0));
    bus_read(2'd2, rv); void'(m_read(2'd2));
    chk("long_rd_addr", rv, 16'h0102);

    // RD_N and WR_N both low: idle, bus not driven
    @(negedge clk);
    hpi_if.OTG_ADDR = 2'd0; hpi_if.OTG_CS_N = 0;
    hpi_if.OTG_RD_N = 0; hpi_if.OTG_WR_N = 0;
    repeat (5) @(negedge clk);
    chk("both_low_z", otg_data, 16'hFFFF);
    hpi_if.OTG_CS_N = 1; hpi_if.OTG_RD_N = 1; hpi_if.OTG_WR_N = 1;
    repeat (2) @(negedge clk);
    bus_read(2'd2, rv); void'(m_read(2'd2));
    chk("both_low_addr", rv, 16'h0102);

    // Reset at T1 of a DATA write aborts it; held strobe not re-detected
    bus_write(2'd2, 16'h0200); m_write(2'd2, 16'h0200);
    loc_post(16'h5A5A);
    old0   = mem_m[0];
    old100 = mem_m[16'h0100];
    @(negedge clk);
    hpi_if.OTG_ADDR = 2'd0; drv_data = 16'hBEEF; drv_en = 1;
    hpi_if.OTG_CS_N = 0; hpi_if.OTG_WR_N = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_int", {15'd0, hpi_if.OTG_INT}, 16'h0000);
    reset = 0;
    m_reset();
    repeat (4) @(negedge clk);
    hpi_if.OTG_CS_N = 1; hpi_if.OTG_WR_N = 1; drv_en = 0;
    repeat (2) @(negedge clk);
    chk("abort_bus_z", otg_data, 16'hFFFF);
    bus_read(2'd2, rv); void'(m_read(2'd2));
    chk("abort_addr", rv, 16'h0000);
    loc_read(12'h100, rv);
    chk("abort_mem_tgt", rv, old100);
    loc_read(12'h000, rv);
    chk("abort_mem_0", rv, old0);

    // Randomized operations against the model
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 11));
      ra = 2'(op % 4);
      if (op < 4) begin
        ev = 16'($urandom);
        bus_write(ra, ev);
        m_write(ra, ev);
      end else if (op < 8) begin
        bus_read(ra, rv);
        ev = m_read(ra);
        chk($sformatf("rnd%0d_rd%0d", i, ra), rv, ev);
      end else if (op == 8) begin
        loc_post(16'($urandom));
      end else if (op == 9) begin
        loc_ack();
      end else if (op == 10) begin
        loc_addr = 12'($urandom);
        loc_read(loc_addr, rv);
        chk($sformatf("rnd%0d_loc", i), rv, mem_m[int'(loc_addr)]);
      end else begin
        loc_wr(12'($urandom), 16'($urandom));
      end
      chk_flags($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
